// File: rtl/truth_sweep_pkg.sv
// Shared types and limits for the truth-table sweeper: FSM state encoding,
// table-width helper and the legal parameter ceilings.
package truth_sweep_pkg;

  localparam int MAX_N_INPUTS      = 8;
  localparam int MAX_SETTLE_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    CAPTURE = 2'd2,
    FINISH  = 2'd3
  } sweep_state_t;

  function automatic int table_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter with a zero flag; paces how long each stimulus
// vector is held before the sweeper samples the block output.
module sweep_settle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  // Decrement stops at zero so a stray dec cannot wrap the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a combinational block through every input vector in ascending order,
// captures its output into a truth table and compares it with an expected one.
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter  int N_INPUTS      = 4,
  parameter  int SETTLE_CYCLES = 2,
  localparam int TABLE_W       = table_width(N_INPUTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [TABLE_W-1:0]  expected_table,
  output logic [N_INPUTS-1:0] drive,
  input  logic                sample,
  output logic                busy,
  output logic                done,
  output logic [TABLE_W-1:0]  table_out,
  output logic                table_valid,
  output logic                match,
  output logic [N_INPUTS:0]   mismatch_count,
  output sweep_state_t        state_dbg
);

  // Control contract: start is a level sampled only in IDLE (ignored while
  // busy); abort has priority over start and over a pending capture; done
  // pulses for the single FINISH cycle and results stay valid until the next
  // accepted start or any abort.

  localparam int IDX_W    = N_INPUTS + 1;
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES > 0) ? SETTLE_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_W - 1);

  if ((N_INPUTS < 1) || (N_INPUTS > MAX_N_INPUTS)) begin : g_bad_n_inputs
    $error("truth_table_sweeper: N_INPUTS out of range");
  end
  if ((SETTLE_CYCLES < 0) || (SETTLE_CYCLES > MAX_SETTLE_CYCLES)) begin : g_bad_settle
    $error("truth_table_sweeper: SETTLE_CYCLES out of range");
  end

  sweep_state_t        state_q;
  sweep_state_t        state_d;
  logic [IDX_W-1:0]    index_q;
  logic [TABLE_W-1:0]  exp_q;
  logic [TABLE_W-1:0]  table_q;
  logic [IDX_W-1:0]    mm_q;
  logic                valid_q;

  logic                accept;
  logic                capture;
  logic                timer_load;
  logic                timer_dec;
  logic                timer_zero;
  logic                last_vec;
  logic                exp_bit;

  assign last_vec = (index_q == LAST_IDX);
  assign exp_bit  = exp_q[index_q[N_INPUTS-1:0]];

  sweep_settle_timer #(
    .WIDTH (SETTLE_W)
  ) u_settle (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (SETTLE_LOAD),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every new vector enters HOLD with the timer reloaded; with no settle time
  // the vector goes straight to its capture cycle.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    capture    = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          accept     = 1'b1;
          timer_load = 1'b1;
          if (SETTLE_CYCLES == 0) state_d = CAPTURE;
          else                    state_d = HOLD;
        end
      end
      HOLD: begin
        if (abort)           state_d = IDLE;
        else if (timer_zero) state_d = CAPTURE;
        else                 timer_dec = 1'b1;
      end
      CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          capture = 1'b1;
          if (last_vec) begin
            state_d = FINISH;
          end else begin
            timer_load = 1'b1;
            if (SETTLE_CYCLES == 0) state_d = CAPTURE;
            else                    state_d = HOLD;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q <= '0;
      exp_q   <= '0;
      table_q <= '0;
      mm_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        exp_q   <= expected_table;
        table_q <= '0;
        mm_q    <= '0;
        index_q <= '0;
        valid_q <= 1'b0;
      end
      if (capture) begin
        table_q[index_q[N_INPUTS-1:0]] <= sample;
        if (sample != exp_bit) mm_q <= mm_q + 1'b1;
        // The index parks on the last vector; drive is gated off outside busy.
        if (last_vec) valid_q <= 1'b1;
        else          index_q <= index_q + 1'b1;
      end
      if (abort) valid_q <= 1'b0;
    end
  end

  assign busy           = (state_q == HOLD) || (state_q == CAPTURE);
  assign done           = (state_q == FINISH);
  assign drive          = busy ? index_q[N_INPUTS-1:0] : '0;
  assign table_out      = table_q;
  assign table_valid    = valid_q;
  assign match          = valid_q && (mm_q == '0);
  assign mismatch_count = mm_q;
  assign state_dbg      = state_q;

endmodule
